wptr_full_lvl: RTL
==================

Name: wptr_full_lvl

Overview:
Parametrised successor to the write-side pointer/full-flag logic of the asynchronous FIFO. It runs entirely in the write clock domain and takes the read pointer after it has been synchronised into that domain (Gray code).
- Generates the binary RAM write address and the Gray write pointer.
- Registers full and programmable almost-full flags.
- Reports a fill level.
- Keeps a sticky overflow flag for writes attempted while full.

Parameters:
ADDRSIZE, 4, address width; DEPTH = 2**ADDRSIZE entries; pointers are ADDRSIZE+1 bits.
AFULL_RESET, 2**ADDRSIZE-1, almost-full threshold used when afull_thresh input is 0.

Ports:
wclk  in  1  write-domain clock, all logic on rising edge.
wrst  in  1  synchronous, active-high reset.
winc  in  1  write request for this cycle.
wq2_rptr  in  ADDRSIZE+1  read pointer, Gray code, already synchronised to wclk.
afull_thresh  in  ADDRSIZE+1  almost-full threshold in entries; 0 selects AFULL_RESET; values >DEPTH clamp to DEPTH.
ovf_clr  in  1  clears wovf.
peak_clr  in  1  clears wpeak (optional feature).
waddr  out  ADDRSIZE  binary RAM write address = wbin[ADDRSIZE-1:0].
wptr  out  ADDRSIZE+1  registered Gray write pointer, to be synchronised to the read side.
wfull  out  1  registered full flag.
awfull  out  1  registered almost-full flag.
wlevel  out  ADDRSIZE+1  registered fill level, 0..DEPTH.
wovf  out  1  sticky overflow flag.
wpeak  out  ADDRSIZE+1  highest wlevel since reset/peak_clr (optional feature).

Behaviour:
- Reset, on a wclk edge while wrst=1: wbin=0, wptr=0, wfull=0, awfull=0, wlevel=0, wovf=0, wpeak=0. wrst overrides every other input in that cycle, including a mid-burst winc.
- Write accept: wr_ok = winc & ~wfull.
- Next binary pointer: wbinnext = wbin + wr_ok, modulo 2**(ADDRSIZE+1). The pointer wraps from 2*DEPTH-1 to 0.
- Gray conversion: wgraynext = (wbinnext>>1) ^ wbinnext. wbin and wptr are registered together, so wptr is always the Gray code of wbin.
- Read-pointer decode: rbin = Gray-to-binary of wq2_rptr, combinational XOR prefix chain from the MSB down.
- Level: lvlnext = (wbinnext - rbin) modulo 2**(ADDRSIZE+1), always in 0..DEPTH for legal inputs. wlevel <= lvlnext every edge.
- Full: wfull <= (lvlnext == DEPTH). This is equivalent to wgraynext equalling wq2_rptr with its two MSBs inverted.
- Almost-full: awfull <= (lvlnext >= thr), where thr = AFULL_RESET if afull_thresh==0, else min(afull_thresh, DEPTH).
- Flag latency: all flags reflect the write performed at the same edge and the wq2_rptr sampled at that edge. Example: the 16th write into an empty 16-entry FIFO sets wfull at that edge.
- Pessimism: level and flags are conservative, because wq2_rptr lags the true read pointer. wfull deasserts only at the first edge after wq2_rptr advances.
- Overflow:
  - winc=1 while wfull=1 → write dropped; wbin, wptr, waddr unchanged; wovf <= 1 at that edge.
  - ovf_clr=1 → wovf <= 0.
  - ovf_clr and a new overflow in the same cycle → set wins, wovf=1.
- Simultaneous read advance and write while full: wr_ok=0 (wfull is still 1), and wfull is recomputed from the new wq2_rptr.
- Illegal input: wq2_rptr implying a level >DEPTH is not checked; wlevel is undefined in that case.

Optional Feature:
Macro WPTR_FULL_LVL_PEAK_EN.
- Defined: wpeak <= max(wpeak, lvlnext) every edge. peak_clr=1 loads lvlnext instead, so the current level is never lost.
- Undefined: wpeak is driven constant 0, peak_clr is ignored, and no peak register is synthesised.
- Port list is identical in both builds.

Test Plan:
All scenarios use ADDRSIZE=4, DEPTH=16.
1. Reset: wrst=1 with winc=1 for 3 edges → wptr=0, waddr=0, wfull=0, awfull=0, wlevel=0, wovf=0.
2. Fill: wq2_rptr=0, afull_thresh=0, 16 consecutive winc → awfull=1 at the edge where wlevel=15; then wfull=1, wlevel=16, wptr=5'b11000, waddr=0.
3. Overflow: from full, winc=1 for 2 cycles → wptr stays 5'b11000 and wovf=1. Then ovf_clr=1 with winc=1 in the same cycle → wovf stays 1. ovf_clr alone → wovf=0.
4. Threshold: afull_thresh=12, 12 writes → awfull=1 when wlevel=12, 0 at wlevel=11. afull_thresh=20 → behaves as 16.
5. Wrap: after 16 writes, drive wq2_rptr=5'b11000 (rbin=16) → next edge wfull=0, wlevel=0. Then 16 more writes → wbin wraps from 31 to 0, wptr=5'b00000, wfull=1.
6. Peak (macro defined): write to level 10, then move wq2_rptr to level 4 → wpeak=10; peak_clr → wpeak=4. With the macro undefined → wpeak=0 throughout.

Source files
------------

// File: rtl/wptr_full_lvl.sv
`default_nettype none
// ============================================================================
// Module   : wptr_full_lvl
// Brief    : Write-domain pointer, full/almost-full flags, fill level and
//            sticky overflow for an asynchronous FIFO. Define
//            WPTR_FULL_LVL_PEAK_EN to enable the peak-level tracker (wpeak).
// Revision : 1.0 - initial release
// ============================================================================
module wptr_full_lvl #(
    parameter int ADDRSIZE    = 4,
    parameter int AFULL_RESET = 2**ADDRSIZE - 1
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                ovf_clr,
    input  logic                peak_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                awfull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf,
    output logic [ADDRSIZE:0]   wpeak
);

    localparam int              c_PW          = ADDRSIZE + 1;
    localparam logic [c_PW-1:0] c_DEPTH       = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [c_PW-1:0] c_AFULL_RESET = AFULL_RESET[c_PW-1:0];

    logic [c_PW-1:0] r_wbin;
    logic [c_PW-1:0] r_wptr;
    logic            r_wfull;
    logic            r_awfull;
    logic [c_PW-1:0] r_wlevel;
    logic            r_wovf;

    logic            w_wr_ok;
    logic [c_PW-1:0] w_wbinnext;
    logic [c_PW-1:0] w_wgraynext;
    logic [c_PW-1:0] w_rbin;
    logic [c_PW-1:0] w_lvlnext;
    logic [c_PW-1:0] w_thr;

    assign w_wr_ok     = winc & ~r_wfull;
    assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_wr_ok};
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    generate
        for (genvar i = 0; i < c_PW; i++) begin : g_g2b
            assign w_rbin[i] = ^wq2_rptr[c_PW-1:i];
        end
    endgenerate

    assign w_lvlnext = w_wbinnext - w_rbin;

    always_comb begin
        w_thr = afull_thresh;
        if (afull_thresh == '0) begin
            w_thr = c_AFULL_RESET;
        end else if (afull_thresh > c_DEPTH) begin
            w_thr = c_DEPTH;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_awfull <= 1'b0;
            r_wlevel <= '0;
            r_wovf   <= 1'b0;
        end else begin
            r_wbin   <= w_wbinnext;
            r_wptr   <= w_wgraynext;
            r_wfull  <= (w_lvlnext == c_DEPTH);
            r_awfull <= (w_lvlnext >= w_thr);
            r_wlevel <= w_lvlnext;
            // A dropped write outranks a clear in the same cycle.
            if (winc && r_wfull) begin
                r_wovf <= 1'b1;
            end else if (ovf_clr) begin
                r_wovf <= 1'b0;
            end
        end
    end

`ifdef WPTR_FULL_LVL_PEAK_EN
    logic [c_PW-1:0] r_wpeak;

    // Clearing reloads the current level so an in-progress peak is not lost.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wpeak <= '0;
        end else if (peak_clr || (w_lvlnext > r_wpeak)) begin
            r_wpeak <= w_lvlnext;
        end
    end

    assign wpeak = r_wpeak;
`else
    logic w_unused_peak_clr;
    assign w_unused_peak_clr = peak_clr;
    assign wpeak             = '0;
`endif

    assign waddr  = r_wbin[ADDRSIZE-1:0];
    assign wptr   = r_wptr;
    assign wfull  = r_wfull;
    assign awfull = r_awfull;
    assign wlevel = r_wlevel;
    assign wovf   = r_wovf;

endmodule
`default_nettype wire
